// File: rtl/list_sum_pkg.sv
// Shared types and defaults for the list-sum scheduler slice.
package list_sum_pkg;

  localparam int LS_AW = 8;
  localparam int LS_DW = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  // Width of the round-robin pointer and grant index for n requesters.
  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/list_sum_scheduler_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// The scheduler registers both the pick and the pointer.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] pick_idx
);

  // Scan N positions starting at ptr; the first set request wins.
  always_comb begin
    logic found;
    int   idx;
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/list_sum_scheduler.sv
// Round-robin scheduler sharing one linked-list-sum datapath among N requesters.
// Optional: define LIST_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYCLES and
// report a timed-out op through err alongside its ack.
module list_sum_scheduler
  import list_sum_pkg::*;
#(
  parameter int N              = 4,
  parameter int AW             = LS_AW,
  parameter int DW             = LS_DW,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*AW-1:0] head_addr,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    ack,
  output logic [DW-1:0]   result,
  output logic            err,
  output logic            busy,
  output logic            fsm_start,
  output logic [AW-1:0]   fsm_head,
  input  logic            fsm_done,
  input  logic [DW-1:0]   fsm_sum
);

  localparam int PW = ptr_w(N);

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [N-1:0]  pick;
  logic [PW-1:0] pick_idx;
  logic          tmo;

  rr_arbiter #(.N(N), .PW(PW)) u_arb (
    .req      (req),
    .ptr      (ptr),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  assign busy = (state != IDLE);
  assign ack  = (state == RESP) ? gnt : '0;

`ifdef LIST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;

  // WAIT-cycle counter; tmo fires on the TIMEOUT_CYCLES-th WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                tcnt <= '0;
    else if (state == ISSUE) tcnt <= '0;
    else if (state == WAIT)  tcnt <= tcnt + 1'b1;
  end

  assign tmo = (state == WAIT) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // err rides with the ack of a timed-out op and clears after RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           err <= 1'b0;
    else if (state == WAIT && !fsm_done && tmo) err <= 1'b1;
    else if (state == RESP)             err <= 1'b0;
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  // Main sequencer: arbitrate, issue, wait for DONE, respond, drain DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gidx      <= '0;
      gnt       <= '0;
      result    <= '0;
      fsm_start <= 1'b0;
      fsm_head  <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          gnt       <= pick;
          gidx      <= pick_idx;
          fsm_head  <= head_addr[int'(pick_idx)*AW +: AW];
          fsm_start <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: if (fsm_done) begin
          result    <= fsm_sum;
          fsm_start <= 1'b0;
          state     <= RESP;
        end else if (tmo) begin
          result    <= '0;
          fsm_start <= 1'b0;
          state     <= RESP;
        end
        RESP: begin
          ptr   <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
          gnt   <= '0;
          state <= DRAIN;
        end
        DRAIN: if (!fsm_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
